vga_pattern_gen: RTL



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing.sv | 103 ++++++++++
 rtl/vga_pattern_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA pattern generator.
// The optional scrolling feature is selected with VGA_PATTERN_SCROLL_EN.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_DIAG = 2'd0,
    MODE_ANTI = 2'd1,
    MODE_GRID = 2'd2,
    MODE_BARS = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int NUM_BARS = 8;

  // Drive a sync line to its asserted level when pulse is set, else the idle level.
  function automatic logic sync_level(input logic pulse, input logic pol);
    return pulse ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, sync / active-video generation and frame_start pulse.
// Exposes the live counter state so pattern logic can register in lock-step.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_POL   = 0,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [XW-1:0] h_cnt,
  output logic [YW-1:0] v_cnt,
  output logic          active,
  output logic          line_end,
  output logic          frame_end,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          frame_start
);

  localparam logic          POL       = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT     = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_LO = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_HI = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_ONE     = XW'(1);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT     = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_LO = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_HI = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_ONE     = YW'(1);

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    line_end  = (h_cnt_q == H_LAST);
    frame_end = line_end && (v_cnt_q == V_LAST);

    if (line_end) begin
      h_cnt_d = '0;
    end else begin
      h_cnt_d = h_cnt_q + H_ONE;
    end

    // Vertical count only moves on the last pixel of a line.
    if (frame_end) begin
      v_cnt_d = '0;
    end else if (line_end) begin
      v_cnt_d = v_cnt_q + V_ONE;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    de_d          = active;
    hs_d          = sync_level((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI), POL);
    vs_d          = sync_level((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI), POL);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~POL;
      vs_q          <= ~POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: diagonal, anti-diagonal, grid and colour bars.
// Define VGA_PATTERN_SCROLL_EN to scroll modes 0-2 horizontally by one pixel per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CW         = 4,
  parameter int SYNC_POL   = 0,
  parameter int GRID_LOG2  = 5,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] fg_color,
  output logic [CW-1:0]   VGA_R,
  output logic [CW-1:0]   VGA_G,
  output logic [CW-1:0]   VGA_B,
  output logic            VGA_HS_O,
  output logic            VGA_VS_O,
  output logic            de,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic            frame_start
);

  localparam int            BAR_W    = H_ACTIVE / NUM_BARS;
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [XW:0]   ANTI_SUM = (XW + 1)'(V_ACTIVE - 1);

  logic [XW-1:0] h_cnt_s;
  logic [YW-1:0] v_cnt_s;
  logic          active_s;
  logic          line_end_s;
  logic          frame_end_s;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt_s),
    .v_cnt       (v_cnt_s),
    .active      (active_s),
    .line_end    (line_end_s),
    .frame_end   (frame_end_s),
    .hs          (VGA_HS_O),
    .vs          (VGA_VS_O),
    .de          (de),
    .frame_start (frame_start)
  );

  logic [XW-1:0]   bar_pix_q, bar_pix_d;
  logic [2:0]      bar_k_q, bar_k_d;
  mode_e           mode_q, mode_d;
  logic [3*CW-1:0] fg_q, fg_d;
  logic [3*CW-1:0] rgb_q, rgb_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW:0]     xe_s, ye_s;
  logic            lit_s;

  // Bar counter tracks h_cnt without a divider; the last bar holds to the line end.
  always_comb begin
    if (line_end_s) begin
      bar_pix_d = '0;
      bar_k_d   = 3'd0;
    end else if (bar_k_q == 3'd7) begin
      bar_pix_d = bar_pix_q;
      bar_k_d   = bar_k_q;
    end else if (bar_pix_q == BAR_LAST) begin
      bar_pix_d = '0;
      bar_k_d   = bar_k_q + 3'd1;
    end else begin
      bar_pix_d = bar_pix_q + X_ONE;
      bar_k_d   = bar_k_q;
    end
  end

  always_comb begin
    if (frame_end_s) begin
      mode_d = mode_e'(mode);
      fg_d   = fg_color;
    end else begin
      mode_d = mode_q;
      fg_d   = fg_q;
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [XW+7:0] xs_sum_s;

  always_comb begin
    if (frame_end_s) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    xs_sum_s = (XW + 8)'(h_cnt_s) + (XW + 8)'(frame_cnt_q);
    xe_s     = {1'b0, xs_sum_s[XW-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  always_comb begin
    xe_s = {1'b0, h_cnt_s};
  end
`endif

  always_comb begin
    ye_s  = (XW + 1)'(v_cnt_s);
    lit_s = 1'b0;
    case (mode_q)
      MODE_DIAG: lit_s = (xe_s == ye_s);
      MODE_ANTI: lit_s = ((xe_s + ye_s) == ANTI_SUM);
      MODE_GRID: lit_s = (xe_s[GRID_LOG2-1:0] == '0) || (ye_s[GRID_LOG2-1:0] == '0);
      default:   lit_s = 1'b0;
    endcase

    if (!active_s) begin
      rgb_d = '0;
    end else if (mode_q == MODE_BARS) begin
      rgb_d = {{CW{bar_k_q[2]}}, {CW{bar_k_q[1]}}, {CW{bar_k_q[0]}}};
    end else if (lit_s) begin
      rgb_d = fg_q;
    end else begin
      rgb_d = '0;
    end

    if (active_s) begin
      x_d = h_cnt_s;
      y_d = v_cnt_s;
    end else begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_pix_q <= '0;
      bar_k_q   <= 3'd0;
      mode_q    <= MODE_DIAG;
      fg_q      <= '1;
      rgb_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_k_q   <= bar_k_d;
      mode_q    <= mode_d;
      fg_q      <= fg_d;
      rgb_q     <= rgb_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign VGA_R = rgb_q[3*CW-1:2*CW];
  assign VGA_G = rgb_q[2*CW-1:CW];
  assign VGA_B = rgb_q[CW-1:0];
  assign x     = x_q;
  assign y     = y_q;

endmodule
